pulse_stat_scheduler: RTL and testbench
=======================================

PULSE_STAT_SCHEDULER -- requirements
Module: pulse_stat_scheduler

Interface
REQ-001 SHALL provide parameter WINDOW_CYCLES, default 50000: ACCUM window length in clk cycles, range 2..2^24-1.
REQ-002 SHALL provide parameter DIV_LATENCY, default 4: divider pipeline latency in clk cycles, range 1..15.
REQ-003 SHALL have one clock; reset is asynchronous and active-low: clk input 1, rising-edge system clock; rst_n input 1, asynchronous active-low reset.
REQ-004 is_machine  input  1  machining enable; windows run only while high.
REQ-005 normal_rate_in, arc_rate_in, open_rate_in, short_rate_in  input  8 each  percent rates from the statistics datapath; 8'hFF = invalid/overflow.
REQ-006 feedback_finished  output  1  clears the statistics datapath counters and dividers; high exactly during CLEAR.
REQ-007 rate_valid  output  1  captured rate set available.
REQ-008 rate_ready  input  1  consumer accepts the set when rate_valid is also high.
REQ-009 normal_rate, arc_rate, open_rate, short_rate  output  8 each  captured rates, stable while rate_valid is high.
REQ-010 rate_invalid  output  1  captured set contained at least one 8'hFF.
REQ-011 window_id  output  16  index of the captured set; wraps at 16'hFFFF -> 0.
REQ-012 overrun_count  output  8  count of unconsumed sets overwritten; saturates at 8'hFF.
REQ-013 busy  output  1  high whenever the state is not IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, CLEAR, ACCUM, SETTLE, CAPTURE.
REQ-015 IDLE: when is_machine is sampled 1, next state CLEAR; otherwise remain in IDLE.
REQ-016 CLEAR: lasts exactly 1 cycle; next state ACCUM if is_machine is 1, else IDLE.
REQ-017 feedback_finished SHALL be driven directly by a dedicated flop, never by combinational decode, and SHALL be high only in CLEAR cycles.
REQ-018 ACCUM: a 24-bit window counter runs from 0 to WINDOW_CYCLES-1, so ACCUM lasts exactly WINDOW_CYCLES cycles; at the terminal count, next state SETTLE.
REQ-019 ACCUM: is_machine sampled 0 aborts the window; next state CLEAR, then IDLE; no capture; window_id unchanged.
REQ-020 SETTLE: lasts exactly DIV_LATENCY cycles; next state CAPTURE; is_machine is ignored in SETTLE.
REQ-021 CAPTURE: lasts 1 cycle; latches the four rate inputs into the rate outputs.
REQ-022 CAPTURE: rate_invalid <= OR of (each input == 8'hFF).
REQ-023 CAPTURE: window_id <= window_id + 1 (mod 2^16); rate_valid <= 1 on the following edge; next state CLEAR.
REQ-024 Handshake: rate_valid clears on the edge where rate_valid and rate_ready are both 1; outputs do not change while rate_valid is 1 and no capture occurs.
REQ-025 Overrun: if CAPTURE occurs while rate_valid is 1 and rate_ready is 0, the new set overwrites the old one, rate_valid stays 1, and overrun_count increments (saturating).
REQ-026 Simultaneous capture and consume (rate_valid=1, rate_ready=1 in CAPTURE): the old set counts as consumed, the new set is loaded, rate_valid stays 1, and there is no overrun.
REQ-027 Total latency from ACCUM end to rate_valid = DIV_LATENCY + 2 cycles.

Reset
REQ-028 On rst_n low, asynchronously: state=IDLE, window counter=0, feedback_finished=0, rate_valid=0, all rate outputs=0, rate_invalid=0, window_id=0, overrun_count=0, busy=0.
REQ-029 Reset asserted mid-window SHALL discard all progress; after release the block re-enters via IDLE -> CLEAR.

Verification (WINDOW_CYCLES=16, DIV_LATENCY=3)
REQ-030 is_machine rises (sampled at edge k), rates 40/10/30/20, rate_ready=1 -> feedback_finished high during cycle k+1 only; rate_valid high during cycle k+22; window_id=1; rate outputs 40/10/30/20; rate_invalid=0.
REQ-031 is_machine drops during the 8th ACCUM cycle -> one CLEAR cycle, then IDLE; rate_valid stays 0; window_id stays 0.
REQ-032 rate_ready=0 for 3 windows -> rate_valid stays 1; outputs show window 3's set; window_id=3; overrun_count=2.
REQ-033 rate_ready=1 coincident with the CAPTURE cycle while rate_valid=1 -> new set loaded, rate_valid stays 1, overrun_count unchanged.
REQ-034 arc_rate_in=8'hFF at CAPTURE -> rate_invalid=1, arc_rate=8'hFF.
REQ-035 rst_n pulsed low during SETTLE -> all outputs reset immediately; no capture on release; window_id=0.

Source files
------------

// File: rtl/pulse_stat_scheduler.sv
// Sequences clear / accumulate / settle / capture windows for the pulse statistics datapath
// and holds each captured rate set behind a valid/ready handshake with overrun counting.
module pulse_stat_scheduler #(
   parameter int unsigned WINDOW_CYCLES = 50000,
   parameter int unsigned DIV_LATENCY   = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        is_machine,
   input  logic [7:0]  normal_rate_in,
   input  logic [7:0]  arc_rate_in,
   input  logic [7:0]  open_rate_in,
   input  logic [7:0]  short_rate_in,
   output logic        feedback_finished,
   output logic        rate_valid,
   input  logic        rate_ready,
   output logic [7:0]  normal_rate,
   output logic [7:0]  arc_rate,
   output logic [7:0]  open_rate,
   output logic [7:0]  short_rate,
   output logic        rate_invalid,
   output logic [15:0] window_id,
   output logic [7:0]  overrun_count,
   output logic        busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_ACCUM,
      S_SETTLE,
      S_CAPTURE
   } state_e;

   localparam logic [23:0] WIN_LAST    = 24'(WINDOW_CYCLES - 1);
   localparam logic [23:0] SETTLE_LAST = 24'(DIV_LATENCY - 1);

   state_e      state_q, state_d;
   logic [23:0] cnt_q, cnt_d;
   logic        clear_q;
   logic        valid_q, valid_d;
   logic [31:0] rates_q, rates_d;
   logic        inv_q, inv_d;
   logic [15:0] wid_q, wid_d;
   logic [7:0]  ovr_q, ovr_d;
   logic        capture;

   // One counter serves both the accumulation window and the settle delay.
   always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      unique case (state_q)
         S_IDLE:    if (is_machine) state_d = S_CLEAR;
         S_CLEAR:   state_d = is_machine ? S_ACCUM : S_IDLE;
         S_ACCUM: begin
            if (!is_machine)           state_d = S_CLEAR;
            else if (cnt_q == WIN_LAST) state_d = S_SETTLE;
            else                        cnt_d   = cnt_q + 24'd1;
         end
         S_SETTLE: begin
            if (cnt_q == SETTLE_LAST) state_d = S_CAPTURE;
            else                      cnt_d   = cnt_q + 24'd1;
         end
         S_CAPTURE: state_d = S_CLEAR;
         default:   state_d = S_IDLE;
      endcase
   end

   assign capture = (state_q == S_CAPTURE);

   // A capture always wins over a same-cycle consume, so valid stays high then.
   always_comb begin
      valid_d = capture | (valid_q & ~rate_ready);
      rates_d = rates_q;
      inv_d   = inv_q;
      wid_d   = wid_q;
      ovr_d   = ovr_q;
      if (capture) begin
         rates_d = {normal_rate_in, arc_rate_in, open_rate_in, short_rate_in};
         inv_d   = (normal_rate_in == 8'hFF) | (arc_rate_in == 8'hFF) |
                   (open_rate_in == 8'hFF) | (short_rate_in == 8'hFF);
         wid_d   = wid_q + 16'd1;
         if (valid_q && !rate_ready && ovr_q != 8'hFF) ovr_d = ovr_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         clear_q <= 1'b0;
         valid_q <= 1'b0;
         rates_q <= '0;
         inv_q   <= 1'b0;
         wid_q   <= '0;
         ovr_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         clear_q <= (state_d == S_CLEAR);
         valid_q <= valid_d;
         rates_q <= rates_d;
         inv_q   <= inv_d;
         wid_q   <= wid_d;
         ovr_q   <= ovr_d;
      end
   end

   assign feedback_finished = clear_q;
   assign rate_valid        = valid_q;
   assign normal_rate       = rates_q[31:24];
   assign arc_rate          = rates_q[23:16];
   assign open_rate         = rates_q[15:8];
   assign short_rate        = rates_q[7:0];
   assign rate_invalid      = inv_q;
   assign window_id         = wid_q;
   assign overrun_count     = ovr_q;
   assign busy              = (state_q != S_IDLE);

endmodule

// File: tb/tb_pulse_stat_scheduler.sv
// Self-checking bench for pulse_stat_scheduler: directed scenarios with WINDOW_CYCLES=16,
// DIV_LATENCY=3, then randomized traffic against a window-position reference model.
module tb_pulse_stat_scheduler;

   localparam int W = 16;
   localparam int D = 3;

   logic        clk;
   logic        rst_n;
   logic        is_machine;
   logic [7:0]  normal_rate_in, arc_rate_in, open_rate_in, short_rate_in;
   logic        feedback_finished;
   logic        rate_valid;
   logic        rate_ready;
   logic [7:0]  normal_rate, arc_rate, open_rate, short_rate;
   logic        rate_invalid;
   logic [15:0] window_id;
   logic [7:0]  overrun_count;
   logic        busy;

   int tests_run    = 0;
   int tests_failed = 0;

   pulse_stat_scheduler #(.WINDOW_CYCLES(W), .DIV_LATENCY(D)) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .is_machine        (is_machine),
      .normal_rate_in    (normal_rate_in),
      .arc_rate_in       (arc_rate_in),
      .open_rate_in      (open_rate_in),
      .short_rate_in     (short_rate_in),
      .feedback_finished (feedback_finished),
      .rate_valid        (rate_valid),
      .rate_ready        (rate_ready),
      .normal_rate       (normal_rate),
      .arc_rate          (arc_rate),
      .open_rate         (open_rate),
      .short_rate        (short_rate),
      .rate_invalid      (rate_invalid),
      .window_id         (window_id),
      .overrun_count     (overrun_count),
      .busy              (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: pos = -1 idle, 0 clear, 1..W accumulate, W+1..W+D settle, W+D+1 capture.
   int          m_pos;
   logic        m_valid;
   logic [31:0] m_rates;
   logic        m_inv;
   logic [15:0] m_wid;
   int          m_ovr;

   function automatic logic [7:0] rand_rate();
      if ($urandom_range(15) == 0) return 8'hFF;
      return 8'($urandom_range(100));
   endfunction

   task automatic model_step();
      if (m_pos == W + D + 1) begin
         if (m_valid && !rate_ready && m_ovr < 255) m_ovr = m_ovr + 1;
         m_rates = {normal_rate_in, arc_rate_in, open_rate_in, short_rate_in};
         m_inv   = (normal_rate_in == 8'hFF) || (arc_rate_in == 8'hFF) ||
                   (open_rate_in == 8'hFF) || (short_rate_in == 8'hFF);
         m_wid   = m_wid + 16'd1;
         m_valid = 1'b1;
      end else if (m_valid && rate_ready) begin
         m_valid = 1'b0;
      end
      if (m_pos == -1)         m_pos = is_machine ? 0 : -1;
      else if (m_pos == 0)     m_pos = is_machine ? 1 : -1;
      else if (m_pos <= W)     m_pos = is_machine ? m_pos + 1 : 0;
      else if (m_pos <= W + D) m_pos = m_pos + 1;
      else                     m_pos = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n      = 1'b0;
      is_machine = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic wait_idle();
      int k = 0;
      while (busy !== 1'b0 && k < 200) begin
         @(negedge clk);
         k++;
      end
      tests_run++;
      if (busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL wait_idle: busy=%b after %0d cycles, required 0", busy, k);
      end
   endtask

   task automatic test_reset();
      #3 rst_n = 1'b0;
      #1;
      tests_run++;
      if ({feedback_finished, rate_valid, normal_rate, arc_rate, open_rate, short_rate,
           rate_invalid, window_id, overrun_count, busy} !== '0) begin
         tests_failed++;
         $display("FAIL reset_outputs: ff=%b v=%b rates=%h inv=%b wid=%h ovr=%h busy=%b, required all 0",
                  feedback_finished, rate_valid, {normal_rate, arc_rate, open_rate, short_rate},
                  rate_invalid, window_id, overrun_count, busy);
      end
      is_machine = 1'b1;
      repeat (3) @(negedge clk);
      tests_run++;
      if (busy !== 1'b0 || feedback_finished !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_held: busy=%b ff=%b, required 0 0", busy, feedback_finished);
      end
      is_machine = 1'b0;
      rst_n      = 1'b1;
   endtask

   task automatic test_single_window();
      do_reset();
      rate_ready = 1'b1;
      {normal_rate_in, arc_rate_in, open_rate_in, short_rate_in} = {8'd40, 8'd10, 8'd30, 8'd20};
      @(negedge clk);
      is_machine = 1'b1;
      for (int n = 1; n <= 23; n++) begin
         @(negedge clk);
         tests_run++;
         if (feedback_finished !== (n == 1 || n == 22)) begin
            tests_failed++;
            $display("FAIL single_ff cycle k+%0d: got %b required %b", n, feedback_finished, (n == 1 || n == 22));
         end
         tests_run++;
         if (rate_valid !== (n == 22)) begin
            tests_failed++;
            $display("FAIL single_valid cycle k+%0d: got %b required %b", n, rate_valid, (n == 22));
         end
         if (n == 22) begin
            tests_run++;
            if ({normal_rate, arc_rate, open_rate, short_rate, rate_invalid, window_id} !==
                {8'd40, 8'd10, 8'd30, 8'd20, 1'b0, 16'd1}) begin
               tests_failed++;
               $display("FAIL single_data: rates=%h inv=%b wid=%0d required 280a1e14 0 1",
                        {normal_rate, arc_rate, open_rate, short_rate}, rate_invalid, window_id);
            end
         end
      end
      is_machine = 1'b0;
      wait_idle();
   endtask

   task automatic test_abort();
      do_reset();
      rate_ready = 1'b1;
      @(negedge clk);
      is_machine = 1'b1;
      for (int n = 1; n <= 12; n++) begin
         @(negedge clk);
         tests_run++;
         if (feedback_finished !== (n == 1 || n == 10) || busy !== (n <= 10) || rate_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort cycle k+%0d: ff=%b busy=%b v=%b required %b %b 0", n,
                     feedback_finished, busy, rate_valid, (n == 1 || n == 10), (n <= 10));
         end
         if (n == 9) is_machine = 1'b0;
      end
      tests_run++;
      if (window_id !== 16'd0) begin
         tests_failed++;
         $display("FAIL abort_wid: got %0d required 0", window_id);
      end
   endtask

   task automatic test_overrun();
      logic [31:0] exp_r;
      logic        exp_inv;
      do_reset();
      rate_ready = 1'b0;
      exp_r = '0;
      exp_inv = 1'b0;
      @(negedge clk);
      is_machine = 1'b1;
      for (int n = 1; n <= 64; n++) begin
         @(negedge clk);
         if (n == 22 || n == 43) begin
            tests_run++;
            if (rate_valid !== 1'b1 || overrun_count !== 8'((n - 22) / 21)) begin
               tests_failed++;
               $display("FAIL overrun_mid k+%0d: v=%b ovr=%0d required 1 %0d", n, rate_valid,
                        overrun_count, (n - 22) / 21);
            end
         end
         {normal_rate_in, arc_rate_in, open_rate_in, short_rate_in} =
            {rand_rate(), rand_rate(), rand_rate(), rand_rate()};
         if (n == 63) begin
            exp_r   = {normal_rate_in, arc_rate_in, open_rate_in, short_rate_in};
            exp_inv = (normal_rate_in == 8'hFF) || (arc_rate_in == 8'hFF) ||
                      (open_rate_in == 8'hFF) || (short_rate_in == 8'hFF);
            is_machine = 1'b0;
         end
      end
      tests_run++;
      if (rate_valid !== 1'b1 || window_id !== 16'd3 || overrun_count !== 8'd2) begin
         tests_failed++;
         $display("FAIL overrun_state: v=%b wid=%0d ovr=%0d required 1 3 2", rate_valid, window_id, overrun_count);
      end
      tests_run++;
      if ({normal_rate, arc_rate, open_rate, short_rate, rate_invalid} !== {exp_r, exp_inv}) begin
         tests_failed++;
         $display("FAIL overrun_data: rates=%h inv=%b required %h %b",
                  {normal_rate, arc_rate, open_rate, short_rate}, rate_invalid, exp_r, exp_inv);
      end
      wait_idle();
   endtask

   task automatic test_simultaneous();
      rate_ready = 1'b0;
      {normal_rate_in, arc_rate_in, open_rate_in, short_rate_in} = {8'd11, 8'd22, 8'd33, 8'd44};
      @(negedge clk);
      is_machine = 1'b1;
      for (int n = 1; n <= 23; n++) begin
         @(negedge clk);
         if (n == 21) rate_ready = 1'b1;
         if (n == 22) begin
            tests_run++;
            if (rate_valid !== 1'b1 || overrun_count !== 8'd2 || window_id !== 16'd4) begin
               tests_failed++;
               $display("FAIL simul_state: v=%b ovr=%0d wid=%0d required 1 2 4", rate_valid, overrun_count, window_id);
            end
            tests_run++;
            if ({normal_rate, arc_rate, open_rate, short_rate} !== {8'd11, 8'd22, 8'd33, 8'd44}) begin
               tests_failed++;
               $display("FAIL simul_data: rates=%h required 0b16212c", {normal_rate, arc_rate, open_rate, short_rate});
            end
            is_machine = 1'b0;
         end
         if (n == 23) begin
            tests_run++;
            if (rate_valid !== 1'b0) begin
               tests_failed++;
               $display("FAIL simul_consume: v=%b required 0", rate_valid);
            end
         end
      end
      rate_ready = 1'b0;
      wait_idle();
   endtask

   task automatic test_invalid();
      do_reset();
      rate_ready = 1'b1;
      {normal_rate_in, arc_rate_in, open_rate_in, short_rate_in} = {8'd5, 8'hFF, 8'd7, 8'd9};
      @(negedge clk);
      is_machine = 1'b1;
      repeat (22) @(negedge clk);
      tests_run++;
      if (rate_valid !== 1'b1 || rate_invalid !== 1'b1 || arc_rate !== 8'hFF || normal_rate !== 8'd5) begin
         tests_failed++;
         $display("FAIL invalid: v=%b inv=%b arc=%h normal=%h required 1 1 ff 05",
                  rate_valid, rate_invalid, arc_rate, normal_rate);
      end
      is_machine = 1'b0;
      wait_idle();
   endtask

   task automatic test_reset_settle();
      rate_ready = 1'b0;
      {normal_rate_in, arc_rate_in, open_rate_in, short_rate_in} = {8'd1, 8'd2, 8'd3, 8'd4};
      @(negedge clk);
      is_machine = 1'b1;
      repeat (19) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      tests_run++;
      if ({feedback_finished, rate_valid, normal_rate, arc_rate, open_rate, short_rate,
           rate_invalid, window_id, overrun_count, busy} !== '0) begin
         tests_failed++;
         $display("FAIL settle_reset: ff=%b v=%b rates=%h inv=%b wid=%h ovr=%h busy=%b, required all 0",
                  feedback_finished, rate_valid, {normal_rate, arc_rate, open_rate, short_rate},
                  rate_invalid, window_id, overrun_count, busy);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int m = 1; m <= 20; m++) begin
         @(negedge clk);
         tests_run++;
         if (rate_valid !== 1'b0 || window_id !== 16'd0 || feedback_finished !== (m == 1) || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL settle_restart m=%0d: v=%b wid=%0d ff=%b busy=%b required 0 0 %b 1",
                     m, rate_valid, window_id, feedback_finished, busy, (m == 1));
         end
      end
      is_machine = 1'b0;
      wait_idle();
   endtask

   task automatic test_random();
      logic [59:0] exp_v, act_v;
      rate_ready = 1'b0;
      do_reset();
      m_pos = -1; m_valid = 1'b0; m_rates = '0; m_inv = 1'b0; m_wid = '0; m_ovr = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clk);
         exp_v = {(m_pos == 0), m_valid, m_rates, m_inv, m_wid, 8'(m_ovr), (m_pos >= 0)};
         act_v = {feedback_finished, rate_valid, normal_rate, arc_rate, open_rate, short_rate,
                  rate_invalid, window_id, overrun_count, busy};
         tests_run++;
         if (act_v !== exp_v) begin
            tests_failed++;
            $display("FAIL random cycle %0d: got %h required %h", cyc, act_v, exp_v);
         end
         if ($urandom_range(39) == 0) is_machine = ~is_machine;
         rate_ready = ($urandom_range(3) == 0);
         {normal_rate_in, arc_rate_in, open_rate_in, short_rate_in} =
            {rand_rate(), rand_rate(), rand_rate(), rand_rate()};
         model_step();
      end
      is_machine = 1'b0;
   endtask

   initial begin
      rst_n      = 1'b1;
      is_machine = 1'b0;
      rate_ready = 1'b0;
      {normal_rate_in, arc_rate_in, open_rate_in, short_rate_in} = '0;
      test_reset();
      test_single_window();
      test_abort();
      test_overrun();
      test_simultaneous();
      test_invalid();
      test_reset_settle();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
